addsub_rr_arbiter: RTL and testbench

Shares one registered WIDTH-bit add/subtract unit between two requesters using round-robin arbitration. Each requester uses a valid/ready handshake to submit an operation: add_sub select plus operands a and b. The block executes one operation at a time and returns result, signed overflow flag and requester ID on a response port with backpressure. It sits between the command sources and the arithmetic datapath and owns that datapath's sequencing.

---
 rtl/addsub_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit add/subtract unit between two requesters.
// Build option: define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_add_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_add_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_q;
  logic             op_add_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_id_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             rsp_id_q;

  logic             grant0, grant1;
  logic             accept;
  logic [WIDTH-1:0] raw_res;
  logic             raw_ovf;
  logic [WIDTH-1:0] final_res;

  // With both valid, the requester that did not win last time gets the grant.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; ready is masked by reset so nothing is accepted in a reset cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = grant0 & ~reset;
        req1_ready = grant1 & ~reset;
      end
      StExec: busy = 1'b1;
      StResp: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    raw_res = op_add_q ? (op_a_q + op_b_q) : (op_a_q - op_b_q);
    if (op_add_q) begin
      raw_ovf = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) & (raw_res[WIDTH-1] != op_a_q[WIDTH-1]);
    end else begin
      raw_ovf = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) & (raw_res[WIDTH-1] != op_a_q[WIDTH-1]);
    end
`ifdef ADDSUB_SAT_EN
    if (raw_ovf) begin
      final_res = op_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_res = raw_res;
    end
`else
    final_res = raw_res;
`endif
  end

  // Operand capture and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= 1'b1;
      op_add_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_id_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      if (state_q == StIdle && accept) begin
        op_add_q <= req1_ready ? req1_add_sub : req0_add_sub;
        op_a_q   <= req1_ready ? req1_a : req0_a;
        op_b_q   <= req1_ready ? req1_b : req0_b;
        op_id_q  <= req1_ready;
        last_q   <= req1_ready;
      end
      if (state_q == StExec) begin
        result_q <= final_res;
        ovf_q    <= raw_ovf;
        rsp_id_q <= op_id_q;
      end
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign rsp_id = rsp_id_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed self-checking bench for addsub_rr_arbiter (WIDTH=8), covering both build options.
module tb_addsub_rr_arbiter;

`ifdef ADDSUB_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_add_sub = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0;
  logic       req1_valid = 1'b0, req1_add_sub = 1'b0;
  logic [7:0] req1_a = '0, req1_b = '0;
  logic       rsp_ready = 1'b0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, ovf, busy;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_rr_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_add_sub(req0_add_sub),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_add_sub(req1_add_sub),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .result(result), .ovf(ovf), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait (bounded) for ready, handshake; returns in EXEC at posedge+1.
  task automatic issue(input int id, input logic add, input logic [7:0] a, input logic [7:0] b,
                       output int waited);
    logic rdy;
    if (id == 0) begin
      req0_valid = 1'b1; req0_add_sub = add; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_add_sub = add; req1_a = a; req1_b = b;
    end
    waited = 0;
    @(negedge clk);
    rdy = (id == 0) ? req0_ready : req1_ready;
    while (!rdy && waited < 20) begin
      waited++;
      @(negedge clk);
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    check_eq("grant", {31'd0, rdy}, 32'd1);
    tick();
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  // From EXEC: check exec cycle, response contents, then consume it.
  task automatic finish(input int id, input logic [7:0] er, input logic eo);
    @(negedge clk);
    check_eq("exec_busy", {31'd0, busy}, 32'd1);
    check_eq("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("result", {24'd0, result}, {24'd0, er});
    check_eq("ovf", {31'd0, ovf}, {31'd0, eo});
    check_eq("rsp_id", {31'd0, rsp_id}, id);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    tick();
  endtask

  initial begin
    int waited;
    int gcount;
    int exp_gid;
    int gcyc [2];

    // Reset with req0 already valid: reset wins (test 6 prologue).
    req0_valid = 1'b1; req0_add_sub = 1'b1; req0_a = 8'd12; req0_b = 8'd44;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;

    // 1: req0 add 12+44, accepted in the first cycle after reset.
    issue(0, 1'b1, 8'd12, 8'd44, waited);
    check_eq("t1_latency", waited, 32'd0);
    finish(0, 8'd56, 1'b0);

    // 2: req1 add 151+162 overflows.
    issue(1, 1'b1, 8'd151, 8'd162, waited);
    finish(1, Sat ? 8'd128 : 8'd57, 1'b1);

    // 3: both valid continuously, rsp_ready held high.
    req0_valid = 1'b1; req0_add_sub = 1'b0; req0_a = 8'd35; req0_b = 8'd13;
    req1_valid = 1'b1; req1_add_sub = 1'b0; req1_a = 8'd20; req1_b = 8'd56;
    rsp_ready = 1'b1;
    gcount = 0; exp_gid = 0; gcyc[0] = -1; gcyc[1] = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check_eq("t3_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        check_eq("t3_grant_id", {31'd0, req1_ready}, exp_gid);
        if (gcyc[exp_gid] >= 0) check_eq("t3_period", c - gcyc[exp_gid], 32'd6);
        gcyc[exp_gid] = c;
        exp_gid ^= 1;
        gcount++;
      end
      if (rsp_valid) begin
        check_eq("t3_result", {24'd0, result}, rsp_id ? 32'd220 : 32'd22);
        check_eq("t3_ovf", {31'd0, ovf}, 32'd0);
      end
    end
    check_eq("t3_grants", gcount, 32'd8);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();

    // 4: req0 sub 100-156, response held under backpressure; req1 waits meanwhile.
    issue(0, 1'b0, 8'd100, 8'd156, waited);
    req1_valid = 1'b1; req1_add_sub = 1'b0; req1_a = 8'd20; req1_b = 8'd56;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("t4_hold_result", {24'd0, result}, Sat ? 32'd127 : 32'd200);
      check_eq("t4_hold_ovf", {31'd0, ovf}, 32'd1);
      check_eq("t4_hold_id", {31'd0, rsp_id}, 32'd0);
      check_eq("t4_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    issue(1, 1'b0, 8'd20, 8'd56, waited);
    check_eq("t4_req1_next", waited, 32'd0);
    finish(1, 8'd220, 1'b0);

    // 5a: reset during EXEC drops the operation (req0 wins, so last becomes 0).
    issue(0, 1'b1, 8'd1, 8'd2, waited);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("t5_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("t5_exec_idle", {31'd0, busy}, 32'd0);
      tick();
    end

    // 5b: reset during RESP.
    issue(0, 1'b1, 8'd3, 8'd4, waited);
    tick();
    @(negedge clk);
    check_eq("t5_in_resp", {31'd0, rsp_valid}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_resp_dropped", {31'd0, rsp_valid}, 32'd0);
    check_eq("t5_result_clr", {24'd0, result}, 32'd0);

    // Simultaneous request after reset goes to requester 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("t5_rr_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("t5_rr_ready1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // 6: reset with req0 valid, accepted immediately after release.
    req0_valid = 1'b1; req0_add_sub = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    reset = 1'b0;
    issue(0, 1'b1, 8'd7, 8'd9, waited);
    check_eq("t6_first_cycle", waited, 32'd0);
    finish(0, 8'd16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
